// File: rtl/ps2_host_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx_pkg
//  Purpose  : Shared types and constants for the PS/2 host transmit path:
//             FSM state encoding, completion status codes, and the common
//             keyboard command bytes.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_host_tx_pkg;

  // Transmitter sequencing states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_e;

  // Frame completion codes reported alongside tx_done
  typedef enum logic [1:0] {
    ST_ACK     = 2'b00,
    ST_NACK    = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  // Frequently sent command bytes and the device acknowledge byte
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Frame slots after the start bit: 0-7 data, 8 parity, 9 stop
  localparam logic [3:0] STOP_IDX = 4'd9;

  // PS/2 uses odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx_if
//  Purpose  : Request/completion handshake between a command source and the
//             PS/2 host transmitter.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;
  import ps2_host_tx_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  status_e    tx_status;

  // Command source side
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  tx_status
  );

  // Transmitter side
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output tx_status
  );

endinterface
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_line_sync
//  Purpose  : Brings the asynchronous PS/2 clock and data line levels into the
//             system clock domain and flags falling edges of the PS/2 clock.
//             Used by both the host transmitter and the keyboard receiver.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_line_sync (
  input  wire  clock,
  input  wire  reset,
  input  wire  i_clk,
  input  wire  i_data,
  output logic o_clk,
  output logic o_data,
  output logic o_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic       r_clk_prev;

  // Two-flop synchronisers plus one history flop for edge detection; idle
  // line level is high so reset loads ones to avoid a spurious fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_clk};
      r_data_sync <= {r_data_sync[0], i_data};
      r_clk_prev  <= r_clk_sync[1];
    end
  end

  assign o_clk  = r_clk_sync[1];
  assign o_data = r_data_sync[1];
  assign o_fall = r_clk_prev & ~r_clk_sync[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device byte transmitter. Inhibits the bus, issues
//             request-to-send, shifts out data/parity/stop on device clock
//             falls, checks the device acknowledge, and reports ACK, NACK or
//             timeout. Lines are driven open-drain through active-high
//             pull-low enables; the pad level is (oe ? 0 : Z).
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES       = 10000,
  parameter int RTS_CYCLES           = 20,
  parameter int FRAME_TIMEOUT_CYCLES = 2000000
) (
  input  wire          clock,
  input  wire          reset,
  ps2_host_tx_if.slave bus,
  input  wire          i_ps2_clk,
  input  wire          i_ps2_data,
  output logic         o_ps2_clk_oe,
  output logic         o_ps2_data_oe,
  output logic         o_rx_suppress
);

  // One counter serves both the inhibit and request-to-send phases
  localparam int CNT_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = $clog2(FRAME_TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] C_RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(CNT_MAX);
  localparam logic [WW-1:0] C_WD_LAST  = WW'(FRAME_TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] C_WD_MAX   = WW'(FRAME_TIMEOUT_CYCLES);

  state_e        r_state,    w_state_next;
  logic [CW-1:0] r_cnt,      w_cnt_next;
  logic [WW-1:0] r_wdog,     w_wdog_next;
  logic [3:0]    r_idx,      w_idx_next;
  logic [9:0]    r_frame,    w_frame_next;   // {stop, parity, data[7:0]}
  logic          r_nack,     w_nack_next;
  logic          r_clk_oe,   w_clk_oe_next;
  logic          r_data_oe,  w_data_oe_next;
  logic          r_done,     w_done_next;
  status_e       r_status,   w_status_next;

  logic          w_clk_s;
  logic          w_data_s;
  logic          w_fall;
  logic          w_watch;
  logic          w_timeout;

  ps2_line_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .i_clk  (i_ps2_clk),
    .i_data (i_ps2_data),
    .o_clk  (w_clk_s),
    .o_data (w_data_s),
    .o_fall (w_fall)
  );

  // The frame watchdog only runs once the device owns the clock
  assign w_watch   = (r_state == SHIFT) || (r_state == ACK) || (r_state == WAIT_IDLE);
  assign w_timeout = w_watch && (r_wdog >= C_WD_LAST);

  // State and output register; a synchronous reset releases both lines at once
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_idx     <= '0;
      r_frame   <= '0;
      r_nack    <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_status  <= ST_ACK;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wdog    <= w_wdog_next;
      r_idx     <= w_idx_next;
      r_frame   <= w_frame_next;
      r_nack    <= w_nack_next;
      r_clk_oe  <= w_clk_oe_next;
      r_data_oe <= w_data_oe_next;
      r_done    <= w_done_next;
      r_status  <= w_status_next;
    end
  end

  // Next-state and next-output logic for the transmit sequence
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wdog_next    = r_wdog;
    w_idx_next     = r_idx;
    w_frame_next   = r_frame;
    w_nack_next    = r_nack;
    w_clk_oe_next  = r_clk_oe;
    w_data_oe_next = r_data_oe;
    w_done_next    = 1'b0;
    w_status_next  = r_status;

    if (w_watch) begin
      w_wdog_next = (r_wdog == C_WD_MAX) ? r_wdog : r_wdog + 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (bus.tx_valid) begin
          w_frame_next  = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
          w_cnt_next    = '0;
          w_clk_oe_next = 1'b1;
          w_state_next  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (r_cnt >= C_INH_LAST) begin
          w_cnt_next     = '0;
          w_data_oe_next = 1'b1;           // start bit
          w_state_next   = RTS;
        end else begin
          w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
      end

      RTS: begin
        if (r_cnt >= C_RTS_LAST) begin
          w_clk_oe_next = 1'b0;            // hand the clock to the device
          w_idx_next    = '0;
          w_wdog_next   = '0;
          w_state_next  = SHIFT;
        end else begin
          w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        end
      end

      SHIFT: begin
        // Each device clock fall moves the line to the next frame slot
        if (w_fall) begin
          w_data_oe_next = ~r_frame[r_idx];
          if (r_idx == STOP_IDX) begin
            w_state_next = ACK;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end

      ACK: begin
        // Device pulls data low during this clock pulse to acknowledge
        if (w_fall) begin
          w_nack_next  = w_data_s;
          w_state_next = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (w_clk_s && w_data_s) begin
          w_done_next   = 1'b1;
          w_status_next = r_nack ? ST_NACK : ST_ACK;
          w_state_next  = IDLE;
        end
      end

      default: begin
        w_clk_oe_next  = 1'b0;
        w_data_oe_next = 1'b0;
        w_state_next   = IDLE;
      end
    endcase

    // A stalled device overrides anything else happening this cycle
    if (w_timeout) begin
      w_clk_oe_next  = 1'b0;
      w_data_oe_next = 1'b0;
      w_done_next    = 1'b1;
      w_status_next  = ST_TIMEOUT;
      w_state_next   = IDLE;
    end
  end

  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_rx_suppress = (r_state != IDLE);
  assign bus.tx_ready  = (r_state == IDLE);
  assign bus.tx_done   = r_done;
  assign bus.tx_status = r_status;

endmodule
`default_nettype wire
